// File: rtl/madd_scan_engine.sv
// Histogram/accumulate engine: DEPTH signed bins loaded by MARK/ADD and scanned MIN/MAX/MADD.
// Loads take 1 cycle; scans take up to DEPTH cycles; result held in RESULT until res_ready.
module madd_scan_engine #(
   parameter int DEPTH  = 16,
   parameter int IDX_W  = $clog2(DEPTH),
   parameter int DATA_W = 4,
   parameter int ACC_W  = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [IDX_W-1:0]  cmd_index,
   input  logic [DATA_W-1:0] cmd_data,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  res_data,
   output logic              res_found,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_RESULT} state_t;

   localparam logic [2:0] OP_CLEAR = 3'b000;
   localparam logic [2:0] OP_MARK  = 3'b001;
   localparam logic [2:0] OP_ADD   = 3'b010;
   localparam logic [2:0] OP_SMIN  = 3'b100;
   localparam logic [2:0] OP_SMAX  = 3'b101;
   localparam logic [2:0] OP_SMADD = 3'b110;
   localparam logic [1:0] MODE_MIN  = 2'b00;
   localparam logic [1:0] MODE_MADD = 2'b10;
   localparam logic [IDX_W-1:0] P_LAST = IDX_W'(DEPTH - 1);
   localparam logic [IDX_W-1:0] P_ZERO = '0;

   state_t                   state_q, state_d;
   logic [IDX_W-1:0]         p_q, p_d;
   logic [1:0]               mode_q, mode_d;
   logic signed [ACC_W-1:0]  delta_q, delta_d, count_q, count_d, total_q, total_d;
   logic signed [ACC_W-1:0]  mem_q [DEPTH];
   logic signed [ACC_W-1:0]  mem_d [DEPTH];
   logic [ACC_W-1:0]         res_data_q, res_data_d;
   logic                     res_found_q, res_found_d;
   logic                     err_q, err_d;

   logic                     accept, is_scan, hit, scan_end;
   logic signed [ACC_W-1:0]  bin, add_amt;

   always_comb begin
      accept   = cmd_valid && (state_q == S_IDLE);
      is_scan  = (cmd_op == OP_SMIN) || (cmd_op == OP_SMAX) || (cmd_op == OP_SMADD);
      bin      = mem_q[p_q];
      hit      = (bin != '0);
      scan_end = (mode_q == MODE_MIN) ? (p_q == P_LAST) : (p_q == P_ZERO);
      add_amt  = ACC_W'(cmd_data);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (accept && is_scan) state_d = S_SCAN;
         S_SCAN: begin
            // MADD never exits early; MIN/MAX stop on the first non-zero bin
            if (mode_q == MODE_MADD) begin
               if (scan_end) state_d = S_RESULT;
            end else if (hit || scan_end) begin
               state_d = S_RESULT;
            end
         end
         S_RESULT: if (res_ready) state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      mem_d       = mem_q;
      p_d         = p_q;
      mode_d      = mode_q;
      delta_d     = delta_q;
      count_d     = count_q;
      total_d     = total_q;
      res_data_d  = res_data_q;
      res_found_d = res_found_q;
      err_d       = err_q;
      if (accept) begin
         case (cmd_op)
            OP_CLEAR: for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            OP_MARK:  mem_d[cmd_index] = mem_q[cmd_index] + ACC_W'(1);
            OP_ADD: begin
               mem_d[cmd_index] = mem_q[cmd_index] + add_amt;
               if (cmd_index != P_ZERO)
                  mem_d[cmd_index - IDX_W'(1)] = mem_q[cmd_index - IDX_W'(1)] - add_amt;
            end
            OP_SMIN, OP_SMAX, OP_SMADD: begin
               mode_d  = cmd_op[1:0];
               p_d     = (cmd_op == OP_SMIN) ? P_ZERO : P_LAST;
               delta_d = '0;
               count_d = '0;
               total_d = '0;
            end
            default:  err_d = 1'b1;
         endcase
      end else if (state_q == S_SCAN) begin
         if (mode_q == MODE_MADD) begin
            delta_d = delta_q + bin;
            count_d = count_q + delta_q + bin;
            total_d = total_q + count_q + delta_q + bin;
            p_d     = p_q - IDX_W'(1);
            if (scan_end) begin
               res_data_d  = total_d;
               res_found_d = 1'b1;
            end
         end else begin
            p_d = (mode_q == MODE_MIN) ? p_q + IDX_W'(1) : p_q - IDX_W'(1);
            if (hit) begin
               res_data_d  = ACC_W'(p_q);
               res_found_d = 1'b1;
            end else if (scan_end) begin
               res_data_d  = '0;
               res_found_d = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         p_q         <= '0;
         mode_q      <= '0;
         delta_q     <= '0;
         count_q     <= '0;
         total_q     <= '0;
         res_data_q  <= '0;
         res_found_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         mem_q       <= mem_d;
         p_q         <= p_d;
         mode_q      <= mode_d;
         delta_q     <= delta_d;
         count_q     <= count_d;
         total_q     <= total_d;
         res_data_q  <= res_data_d;
         res_found_q <= res_found_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      cmd_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      res_valid = (state_q == S_RESULT);
      res_data  = res_data_q;
      res_found = res_found_q;
      err       = err_q;
   end

endmodule
